alu_sequencer: RTL and testbench

Bus-side controller for the 8-bit ALU. It accepts an operation request with two operands and an opcode. It drives the ALU operand registers and select lines, waits for the ALU's registered result, and briefly grants the ALU the shared bus. It then captures the result from the bus and reports completion. It is the initiator and reader on the ALU's enable/bus interface, and is the only block that asserts the ALU output enable.

---
 rtl/alu_sequencer.sv | 111 +++++++++++
 tb/tb_alu_sequencer.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/alu_sequencer.sv
// Bus-side sequencer for the 8-bit ALU: latches a request, lets the ALU compute, grants it the bus for one cycle, captures the result.
// Optional DIVZERO_TRAP_EN: short-circuits DIV by zero to an all-ones result with div_zero flagged.
module alu_sequencer #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] operand_a,
    input  logic [WIDTH-1:0] operand_b,
    output logic [WIDTH-1:0] reg_A,
    output logic [WIDTH-1:0] reg_B,
    output logic [1:0]       sel,
    output logic             alu_en,
    inout  wire  [WIDTH-1:0] bus,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             div_zero
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        READ = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t state, state_nxt;
    logic   accept;
    logic   trap;

    // The ALU owns the bus whenever alu_en is high; this side only listens.
    assign bus = {WIDTH{1'bz}};

    // Handshake: start is taken only in IDLE (busy=0); done is a single-cycle
    // pulse and busy covers acceptance+1 through the done cycle.
    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        trap      = 1'b0;
        alu_en    = 1'b0;
        busy      = 1'b1;
        done      = 1'b0;
        case (state)
            IDLE: begin
                busy = 1'b0;
                if (start) begin
                    accept = 1'b1;
`ifdef DIVZERO_TRAP_EN
                    trap = (op == 2'b11) && (operand_b == '0);
`endif
                    state_nxt = trap ? DONE : EXEC;
                end
            end
            EXEC: state_nxt = READ;
            READ: begin
                alu_en    = 1'b1;
                state_nxt = DONE;
            end
            DONE: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            state  <= IDLE;
            reg_A  <= '0;
            reg_B  <= '0;
            sel    <= 2'b00;
            result <= '0;
            zero   <= 1'b1;
        end else begin
            state <= state_nxt;
            // Operand registers feed the ALU every edge, so they only move on acceptance.
            if (accept) begin
                reg_A <= operand_a;
                reg_B <= operand_b;
                sel   <= op;
            end
            if (state == READ) begin
                result <= bus;
                zero   <= (bus == '0);
            end else if (trap) begin
                result <= '1;
                zero   <= 1'b0;
            end
        end
    end

`ifdef DIVZERO_TRAP_EN
    always_ff @(posedge clk) begin
        if (clr) begin
            div_zero <= 1'b0;
        end else if (state == READ) begin
            div_zero <= 1'b0;
        end else if (trap) begin
            div_zero <= 1'b1;
        end
    end
`else
    assign div_zero = 1'b0;
`endif

endmodule

// File: tb/tb_alu_sequencer.sv
// Bench for alu_sequencer: a behavioural ALU on the shared bus, table-driven back-to-back ops, trap and clear-in-READ sequences.
module tb_alu_sequencer;

  localparam int WIDTH = 8;

  logic             clk = 1'b0;
  logic             clr;
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] operand_a;
  logic [WIDTH-1:0] operand_b;
  logic [WIDTH-1:0] reg_A;
  logic [WIDTH-1:0] reg_B;
  logic [1:0]       sel;
  logic             alu_en;
  wire  [WIDTH-1:0] bus;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             zero;
  logic             div_zero;

  logic [WIDTH-1:0] alu_q;
  logic [WIDTH+1:0] exp_q[$];
  logic [WIDTH+1:0] sb_e;
  logic             prev_en = 1'b0;
  int               n_vec = 0;
  int               n_err = 0;

  typedef struct {
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [1:0]       op;
    logic [WIDTH-1:0] res;
    logic             zero;
  } vec_t;

  vec_t vecs[20];
  int   n_tab = 0;

  alu_sequencer #(.WIDTH(WIDTH)) dut (
    .clk(clk), .clr(clr), .start(start), .op(op),
    .operand_a(operand_a), .operand_b(operand_b),
    .reg_A(reg_A), .reg_B(reg_B), .sel(sel), .alu_en(alu_en), .bus(bus),
    .busy(busy), .done(done), .result(result), .zero(zero), .div_zero(div_zero)
  );

  // clock
  always #5 clk = ~clk;

  // ALU reference: registers on every edge, drives bus only when enabled
  function automatic logic [WIDTH-1:0] alu_f(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                             input logic [1:0] s);
    logic [2*WIDTH-1:0] p;
    p = {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};
    case (s)
      2'b00:   return a + b;
      2'b01:   return a - b;
      2'b10:   return p[WIDTH-1:0];
      default: return (b == '0) ? '1 : a / b;
    endcase
  endfunction

  always @(posedge clk) alu_q <= alu_f(reg_A, reg_B, sel);
  assign bus = alu_en ? alu_q : {WIDTH{1'bz}};

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic add_vec(input int a, input int b, input int o, input int res, input int z);
    vecs[n_tab].a    = a[WIDTH-1:0];
    vecs[n_tab].b    = b[WIDTH-1:0];
    vecs[n_tab].op   = o[1:0];
    vecs[n_tab].res  = res[WIDTH-1:0];
    vecs[n_tab].zero = z[0];
    n_tab++;
  endtask

  // scoreboard: pop one expectation per done pulse
  always @(negedge clk) begin
    if (done) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_done", int'(done), 0);
      end else begin
        sb_e = exp_q.pop_front();
        chk("result", int'(result), int'(sb_e[WIDTH-1:0]));
        chk("zero", int'(zero), int'(sb_e[WIDTH]));
        chk("div_zero", int'(div_zero), int'(sb_e[WIDTH+1]));
      end
    end
    if (alu_en) chk("alu_en_consecutive", int'(prev_en), 0);
    prev_en = alu_en;
  end

  // Called at a negedge in an IDLE cycle; leaves start high and returns at the next IDLE negedge.
  task automatic apply_vec(input vec_t v);
    start     = 1'b1;
    operand_a = v.a;
    operand_b = v.b;
    op        = v.op;
    exp_q.push_back({1'b0, v.zero, v.res});
    @(posedge clk);
    #1;
    operand_a = WIDTH'($urandom_range(0, 255));
    operand_b = WIDTH'($urandom_range(0, 255));
    op        = 2'($urandom_range(0, 3));
    @(negedge clk);
    chk("exec_busy", int'(busy), 1);
    chk("exec_alu_en", int'(alu_en), 0);
    chk("exec_reg_A", int'(reg_A), int'(v.a));
    chk("exec_reg_B", int'(reg_B), int'(v.b));
    chk("exec_sel", int'(sel), int'(v.op));
    @(negedge clk);
    chk("read_alu_en", int'(alu_en), 1);
    chk("read_reg_A", int'(reg_A), int'(v.a));
    chk("read_sel", int'(sel), int'(v.op));
    @(negedge clk);
    chk("done_pulse", int'(done), 1);
    chk("done_alu_en", int'(alu_en), 0);
    chk("done_busy", int'(busy), 1);
    @(negedge clk);
    chk("idle_busy", int'(busy), 0);
    chk("idle_done", int'(done), 0);
  endtask

  initial begin
    int a, b, o, r;
    vec_t v;
    clr = 1'b1; start = 1'b0; op = 2'b00; operand_a = '0; operand_b = '0;
    repeat (2) @(posedge clk);
    #1 clr = 1'b0;
    @(negedge clk);
    chk("rst_reg_A", int'(reg_A), 0);
    chk("rst_reg_B", int'(reg_B), 0);
    chk("rst_sel", int'(sel), 0);
    chk("rst_alu_en", int'(alu_en), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_result", int'(result), 0);
    chk("rst_zero", int'(zero), 1);
    chk("rst_div_zero", int'(div_zero), 0);

    add_vec(200, 100, 0, 44, 0);
    add_vec(5, 7, 1, 254, 0);
    add_vec(20, 20, 2, 144, 0);
    add_vec(100, 7, 3, 14, 0);
    add_vec(9, 9, 1, 0, 1);
    add_vec(255, 1, 0, 0, 1);
    add_vec(16, 16, 2, 0, 1);
    add_vec(7, 100, 3, 0, 1);
    add_vec(0, 1, 1, 255, 0);
    add_vec(255, 255, 2, 1, 0);
    for (int i = 0; i < 6; i++) begin
      o = $urandom_range(0, 3);
      a = $urandom_range(0, 255);
      b = (o == 3) ? $urandom_range(1, 255) : $urandom_range(0, 255);
      r = int'(alu_f(a[WIDTH-1:0], b[WIDTH-1:0], o[1:0]));
      add_vec(a, b, o, r, (r == 0) ? 1 : 0);
    end

    for (int i = 0; i < n_tab; i++) apply_vec(vecs[i]);
    start = 1'b0;

`ifdef DIVZERO_TRAP_EN
    start = 1'b1; operand_a = 8'd50; operand_b = 8'd0; op = 2'b11;
    exp_q.push_back({1'b1, 1'b0, {WIDTH{1'b1}}});
    @(posedge clk);
    #1 start = 1'b0;
    @(negedge clk);
    chk("trap_done", int'(done), 1);
    chk("trap_alu_en", int'(alu_en), 0);
    chk("trap_busy", int'(busy), 1);
    @(negedge clk);
    chk("trap_idle_busy", int'(busy), 0);
    chk("trap_idle_alu_en", int'(alu_en), 0);
`else
    v.a = 8'd50; v.b = 8'd0; v.op = 2'b11; v.res = 8'd255; v.zero = 1'b0;
    apply_vec(v);
    start = 1'b0;
`endif
    v.a = 8'd1; v.b = 8'd1; v.op = 2'b00; v.res = 8'd2; v.zero = 1'b0;
    apply_vec(v);
    start = 1'b0;

    // clear while the ALU holds the bus: no result, no done
    start = 1'b1; operand_a = 8'd3; operand_b = 8'd4; op = 2'b00;
    @(posedge clk);
    #1 start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("clr_pre_alu_en", int'(alu_en), 1);
    clr = 1'b1;
    @(posedge clk);
    #1 clr = 1'b0;
    @(negedge clk);
    chk("clr_busy", int'(busy), 0);
    chk("clr_alu_en", int'(alu_en), 0);
    chk("clr_done", int'(done), 0);
    chk("clr_result", int'(result), 0);
    chk("clr_zero", int'(zero), 1);
    chk("clr_reg_A", int'(reg_A), 0);
    repeat (3) begin
      @(negedge clk);
      chk("clr_no_done", int'(done), 0);
    end

    chk("sb_empty", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
